// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, redirect record and reset default for the fetch sequencer
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic [FETCH_XLEN-1:0] target;
  } redirect_t;

endpackage

// File: rtl/fetch_sequencer_redirect_mux.sv
// rtl/fetch_sequencer_redirect_mux.sv - priority select of exception over branch redirect
module redirect_mux
  import fetch_pkg::*;
(
  input  logic                  i_exc_valid,
  input  logic [FETCH_XLEN-1:0] i_exc_target,
  input  logic                  i_br_valid,
  input  logic [FETCH_XLEN-1:0] i_br_target,
  output redirect_t             o_redirect
);

  always_comb begin
    o_redirect.valid  = i_exc_valid || i_br_valid;
    o_redirect.target = i_exc_valid ? i_exc_target : i_br_target;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC sequencer with single outstanding imem request
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned       INC          = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic            r_req_valid;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst_data;
  logic [XLEN-1:0] r_inst_pc;

  redirect_t       w_redir;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_next;

  redirect_mux u_redirect_mux (
    .i_exc_valid  (exc_valid),
    .i_exc_target (exc_target),
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .o_redirect   (w_redir)
  );

  assign w_target  = w_redir.target[XLEN-1:0];
  assign w_pc_next = r_pc + XLEN'(INC);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VECTOR;
      r_kill       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redir.valid) r_pc <= w_target;
          r_state     <= REQ;
          r_req_valid <= 1'b1;
        end
        REQ: begin
          if (w_redir.valid) r_pc <= w_target;
          if (imem_req_ready) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
            r_kill      <= w_redir.valid;
          end
        end
        WAIT: begin
          if (w_redir.valid) r_pc <= w_target;
          if (imem_rsp_valid) begin
            r_kill <= 1'b0;
            // A redirect in the response cycle squashes it just like a pending kill.
            if (r_kill || w_redir.valid) begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_inst_data  <= imem_rsp_data;
              r_inst_pc    <= r_pc;
              r_pc         <= w_pc_next;
              r_inst_valid <= 1'b1;
              r_state      <= HOLD;
            end
          end else if (w_redir.valid) begin
            r_kill <= 1'b1;
          end
        end
        HOLD: begin
          if (w_redir.valid) r_pc <= w_target;
          if (w_redir.valid || inst_ready) begin
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
            r_state      <= REQ;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_redirect_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_perf_fetch_cnt    <= '0;
      r_perf_redirect_cnt <= '0;
    end else begin
      if (r_inst_valid && inst_ready) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (exc_valid || br_valid) r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt    = r_perf_fetch_cnt;
  assign perf_redirect_cnt = r_perf_redirect_cnt;
`endif

endmodule
